// File: rtl/types_pkg.sv
// Shared decode types, queue defaults and the immediate generator.
package types_pkg;

    localparam int DEC_FETCH_WIDTH = 2;
    localparam int DEC_QUEUE_DEPTH = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_BR  = 2'b01,
        ALU_R   = 2'b10,
        ALU_I   = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic [6:0]  opcode;
        logic        fu_mem;
        logic        fu_alu;
    } decode_data;

    typedef struct packed {
        logic [DEC_FETCH_WIDTH-1:0][31:0] instr;
        logic [31:0]                      pc;
        logic [DEC_FETCH_WIDTH-1:0]       valid;
    } fetch_bundle_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        logic [31:0] imm;
        case (i[6:0])
            OP_I, OP_LOAD, OP_JALR:
                imm = {{20{i[31]}}, i[31:20]};
            OP_STORE:
                imm = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {i[31:12], 12'b0};
            OP_JAL:
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_lane.sv
// One combinational decode lane: raw instruction + pc -> decode_data.
module decode_lane import types_pkg::*; (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output decode_data  dec
);

    logic [6:0] op;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
    alu_op_e    alu_op;
    logic       fu_mem;
    logic       fu_alu;

    always_comb begin
        op      = instr[6:0];
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        alu_op  = ALU_ADD;
        fu_mem  = 1'b0;
        fu_alu  = 1'b0;
        case (op)
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                alu_op  = ALU_R; fu_alu = 1'b1;
            end
            OP_I: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                alu_op  = ALU_I; fu_alu = 1'b1;
            end
            OP_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fu_mem = 1'b1;
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fu_mem = 1'b1;
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                alu_op  = ALU_BR; fu_alu = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                use_rd = 1'b1; fu_alu = 1'b1;
            end
            OP_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fu_alu = 1'b1;
            end
            default: ;
        endcase
    end

    // Unused register fields are zeroed so rename sees no false dependencies.
    always_comb begin
        dec        = '0;
        dec.pc     = pc;
        dec.rs1    = use_rs1 ? instr[19:15] : 5'd0;
        dec.rs2    = use_rs2 ? instr[24:20] : 5'd0;
        dec.rd     = use_rd  ? instr[11:7]  : 5'd0;
        dec.imm    = imm_gen(instr);
        dec.alu_op = alu_op;
        dec.opcode = op;
        dec.fu_mem = fu_mem;
        dec.fu_alu = fu_alu;
    end

endmodule

// File: rtl/decode_queue.sv
// Multi-lane decode stage feeding an in-order output FIFO.
// Optional zero-latency empty-queue bypass: define DECODE_BYPASS_EN.
module decode_queue import types_pkg::*; #(
    parameter int FETCH_WIDTH = DEC_FETCH_WIDTH,
    parameter int DEPTH       = DEC_QUEUE_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FETCH_WIDTH-1:0][31:0] instr,
    input  logic [31:0]                 pc_in,
    input  logic [FETCH_WIDTH-1:0]      valid_in,
    output logic                        ready_in,
    input  logic                        flush,
    input  logic                        ready_out,
    output logic                        valid_out,
    output decode_data                  data_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    decode_data    lane_dec [FETCH_WIDTH];
    decode_data    mem_q    [DEPTH];
    decode_data    mem_d    [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_idx;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_push;
    logic          ready_q, ready_d;
    logic          run;
    logic          push;
    logic          pop;
    logic          bypass;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
        decode_lane u_lane (
            .instr (instr[g]),
            .pc    (pc_in + 32'(4 * g)),
            .dec   (lane_dec[g])
        );
    end

    // Only the contiguous run of valid lanes starting at lane 0 counts.
    always_comb begin
        n_push = '0;
        run    = 1'b1;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            run = run & valid_in[i];
            if (run) n_push = n_push + CW'(1);
        end
    end

`ifdef DECODE_BYPASS_EN
    assign bypass = (count_q == '0) && valid_in[0] && ready_q
                    && ready_out && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        mem_d    = mem_q;
        push     = valid_in[0] && ready_q;
        pop      = (count_q != '0) && ready_out;
        wr_idx   = wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (push && (CW'(i) < n_push) && !(bypass && i == 0)) begin
                    mem_d[wr_idx] = lane_dec[i];
                    wr_idx        = wr_idx + PW'(1);
                end
            end
            wr_ptr_d = wr_idx;
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (push ? n_push : CW'(0))
                      - CW'(bypass) - CW'(pop);
        end
        ready_d = (DEPTH - int'(count_d)) >= FETCH_WIDTH;
    end

    always_comb begin
        valid_out = (count_q != '0) || bypass;
        data_out  = '0;
        if (bypass) begin
            data_out = lane_dec[0];
        end else if (count_q != '0) begin
            data_out = mem_q[rd_ptr_q];
        end
    end

    assign ready_in = ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: an entry is only visible while count covers it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed, table-driven bench for decode_queue (FETCH_WIDTH=2, DEPTH=8).
module tb_decode_queue;
    import types_pkg::*;

    localparam int FW = 2;
    localparam int DP = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [FW-1:0][31:0]  instr;
    logic [31:0]          pc_in;
    logic [FW-1:0]        valid_in;
    logic                 ready_in;
    logic                 flush;
    logic                 ready_out;
    logic                 valid_out;
    decode_data           data_out;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  vin;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [31:0] pc;
        logic        ro;
        logic        fl;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [31:0] e_imm;
        logic        e_mem;
        logic        e_rdy;
    } vec_t;

    decode_queue #(.FETCH_WIDTH(FW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .pc_in     (pc_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .flush     (flush),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc,
                         input logic ro, input logic fl);
        valid_in  = v;
        instr[0]  = i0;
        instr[1]  = i1;
        pc_in     = pc;
        ready_out = ro;
        flush     = fl;
    endtask

    task automatic idle(input logic ro);
        drive(2'b00, 32'h0, 32'h0, 32'h0, ro, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, 32'(valid_out), 32'd1);
        chk({name, "_pc"}, data_out.pc, pc);
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;

    vec_t tbl[$];
    logic [31:0] drain_pc[$];

    initial begin
        reset = 1'b1;
        idle(1'b0);
        #1;
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", 32'(data_out != '0), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("post_rst_ready_in", 32'(ready_in), 32'd1);
        chk("post_rst_valid_out", 32'(valid_out), 32'd0);

        // Push/pop vectors: addi/add pair, masks, load/store, negative imm.
        tbl.push_back('{2'b11, ADDI, 32'h00108133, 32'h100, 1'b0, 1'b0,
                        1'b1, 32'h100, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0,
                        1'b1, 32'h104, 5'd2, 5'd1, 5'd1, 32'd0, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0,
                        1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1});
        tbl.push_back('{2'b10, ADDI, 32'h00108133, 32'h300, 1'b0, 1'b0,
                        1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1});
        tbl.push_back('{2'b01, 32'h00700193, 32'h00108133, 32'h400, 1'b0, 1'b0,
                        1'b1, 32'h400, 5'd3, 5'd0, 5'd0, 32'd7, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0,
                        1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1});
        tbl.push_back('{2'b11, 32'h00812283, 32'h00512623, 32'h500, 1'b0, 1'b0,
                        1'b1, 32'h500, 5'd5, 5'd2, 5'd0, 32'd8, 1'b1, 1'b1});
        tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0,
                        1'b1, 32'h504, 5'd0, 5'd2, 5'd5, 32'd12, 1'b1, 1'b1});
        tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0,
                        1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1});
        tbl.push_back('{2'b01, 32'hFFF00093, 32'h0, 32'h600, 1'b0, 1'b0,
                        1'b1, 32'h600, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0,
                        1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1});

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].vin, tbl[k].i0, tbl[k].i1, tbl[k].pc,
                  tbl[k].ro, tbl[k].fl);
            step();
            chk($sformatf("v%0d_valid", k), 32'(valid_out), 32'(tbl[k].e_valid));
            chk($sformatf("v%0d_pc", k), data_out.pc, tbl[k].e_pc);
            chk($sformatf("v%0d_rd", k), 32'(data_out.rd), 32'(tbl[k].e_rd));
            chk($sformatf("v%0d_rs1", k), 32'(data_out.rs1), 32'(tbl[k].e_rs1));
            chk($sformatf("v%0d_rs2", k), 32'(data_out.rs2), 32'(tbl[k].e_rs2));
            chk($sformatf("v%0d_imm", k), data_out.imm, tbl[k].e_imm);
            chk($sformatf("v%0d_mem", k), 32'(data_out.fu_mem), 32'(tbl[k].e_mem));
            chk($sformatf("v%0d_rdy", k), 32'(ready_in), 32'(tbl[k].e_rdy));
        end

        // Fill to DEPTH with downstream stalled.
        for (int b = 0; b < 4; b++) begin
            drive(2'b11, ADDI, ADDI, 32'h1000 + 32'(8 * b), 1'b0, 1'b0);
            step();
            chk($sformatf("fill%0d_ready_in", b), 32'(ready_in),
                (b == 3) ? 32'd0 : 32'd1);
        end
        chk_head("fill_head", 32'h1000);
        idle(1'b1);
        step();
        chk("pop1_ready_in", 32'(ready_in), 32'd0);
        chk_head("pop1_head", 32'h1004);
        step();
        chk("pop2_ready_in", 32'(ready_in), 32'd1);
        chk_head("pop2_head", 32'h1008);

        // count 6: push a pair and pop one in the same cycle -> 7 entries.
        drive(2'b11, ADDI, ADDI, 32'h2000, 1'b1, 1'b0);
        step();
        chk("conc_ready_in", 32'(ready_in), 32'd0);
        chk_head("conc_head", 32'h100c);
        drain_pc = '{32'h1010, 32'h1014, 32'h1018, 32'h101c,
                     32'h2000, 32'h2004};
        idle(1'b1);
        for (int k = 0; k < drain_pc.size(); k++) begin
            step();
            chk_head($sformatf("drain%0d", k), drain_pc[k]);
        end
        step();
        chk("drain_empty", 32'(valid_out), 32'd0);

        // Flush with a live bundle on the inputs.
        drive(2'b11, ADDI, ADDI, 32'h3000, 1'b0, 1'b0);
        step();
        drive(2'b01, ADDI, ADDI, 32'h3008, 1'b0, 1'b0);
        step();
        chk_head("pre_flush", 32'h3000);
        drive(2'b11, ADDI, ADDI, 32'h3010, 1'b1, 1'b1);
        step();
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_data", 32'(data_out != '0), 32'd0);
        chk("flush_ready_in", 32'(ready_in), 32'd1);
        idle(1'b0);
        step();
        chk("post_flush_valid", 32'(valid_out), 32'd0);
        drive(2'b01, ADDI, ADDI, 32'h3100, 1'b0, 1'b0);
        step();
        chk_head("post_flush_push", 32'h3100);
        idle(1'b1);
        step();
        chk("post_flush_empty", 32'(valid_out), 32'd0);

        // Reset while holding 5 entries.
        drive(2'b11, ADDI, ADDI, 32'h4000, 1'b0, 1'b0);
        step();
        drive(2'b11, ADDI, ADDI, 32'h4008, 1'b0, 1'b0);
        step();
        drive(2'b01, ADDI, ADDI, 32'h4010, 1'b0, 1'b0);
        step();
        chk("cnt5_ready_in", 32'(ready_in), 32'd1);
        chk_head("cnt5_head", 32'h4000);
        idle(1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_data", 32'(data_out != '0), 32'd0);
        chk("midrst_ready_in", 32'(ready_in), 32'd0);
        #3;
        reset = 1'b0;
        step();
        chk("rel_ready_in", 32'(ready_in), 32'd1);
        chk("rel_valid", 32'(valid_out), 32'd0);
        drive(2'b01, ADDI, ADDI, 32'h4100, 1'b0, 1'b0);
        step();
        chk_head("rel_push", 32'h4100);
        idle(1'b1);
        step();
        chk("rel_empty", 32'(valid_out), 32'd0);

`ifdef DECODE_BYPASS_EN
        drive(2'b01, ADDI, ADDI, 32'h200, 1'b1, 1'b0);
        #1;
        chk_head("byp_same_cycle", 32'h200);
        chk("byp_rd", 32'(data_out.rd), 32'd1);
        @(posedge clk);
        #1;
        idle(1'b1);
        #1;
        chk("byp_count0", 32'(valid_out), 32'd0);
        drive(2'b11, ADDI, 32'h00108133, 32'h240, 1'b1, 1'b0);
        #1;
        chk_head("byp2_lane0", 32'h240);
        @(posedge clk);
        #1;
        idle(1'b0);
        #1;
        chk_head("byp2_lane1", 32'h244);
        chk("byp2_rd", 32'(data_out.rd), 32'd2);
        idle(1'b1);
        step();
        chk("byp2_empty", 32'(valid_out), 32'd0);
        drive(2'b01, ADDI, ADDI, 32'h280, 1'b1, 1'b1);
        #1;
        chk("byp_flush_off", 32'(valid_out), 32'd0);
        step();
        idle(1'b0);
        #1;
        chk("byp_flush_empty", 32'(valid_out), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
